// File: rtl/seq_traffic_master.sv
// seq_traffic_master: replays a short sequence of bus transactions against a set of slaves.
// A pass issues NUM_TXN transactions. Transaction i targets slave (i mod SLAVE_COUNT) at
// local offset base_off+i. Modes: 00 read pass, 01 (and 11) write pass, 10 write pass followed
// by a read pass whose data is compared against the write pattern.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   start, mode, base_off sequence request, latched in idle
//   ready, done          idle indicator, one-cycle end-of-sequence pulse
//   ld_en/ld_idx/ld_data write-pattern buffer load (honoured only while idle)
//   rb_idx, rb_data      combinational read-back of the capture buffer
//   err_count, timeout   saturating verify mismatch count, sticky abort flag
//   daddr..dmode         device-side handshake: dvalid pulse, dready low = busy,
//                        dready high again = complete
module seq_traffic_master #(
    parameter int unsigned ADDR_WIDTH           = 16,
    parameter int unsigned DATA_WIDTH           = 8,
    parameter int unsigned SLAVE_MEM_ADDR_WIDTH = 12,
    parameter int unsigned SLAVE_COUNT          = 3,
    parameter int unsigned NUM_TXN              = 8,
    parameter int unsigned TIMEOUT              = 255,
    localparam int unsigned DEV_W = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH,
    localparam int unsigned IW    = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic [1:0]                      mode,
    input  logic [SLAVE_MEM_ADDR_WIDTH-1:0] base_off,
    output logic                            ready,
    output logic                            done,
    input  logic                            ld_en,
    input  logic [IW-1:0]                   ld_idx,
    input  logic [DATA_WIDTH-1:0]           ld_data,
    input  logic [IW-1:0]                   rb_idx,
    output logic [DATA_WIDTH-1:0]           rb_data,
    output logic [7:0]                      err_count,
    output logic                            timeout,
    output logic [ADDR_WIDTH-1:0]           daddr,
    output logic [DATA_WIDTH-1:0]           dwdata,
    input  logic [DATA_WIDTH-1:0]           drdata,
    output logic                            dvalid,
    input  logic                            dready,
    output logic                            dmode
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WaitMax = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle, StIssue, StAccept, StComplete, StNext, StDone
    } state_e;

    state_e                          state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic                            pass_q, pass_d;
    logic [1:0]                      mode_q, mode_d;
    logic [SLAVE_MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]                   wait_q, wait_d;
    logic [7:0]                      err_q, err_d;
    logic                            tmo_q, tmo_d;
    logic                            cap_we;
    logic                            verify_rd;

    logic [DATA_WIDTH-1:0] wbuf_q [NUM_TXN];
    logic [DATA_WIDTH-1:0] cbuf_q [NUM_TXN];

    // mode_q only ever holds 00, 01 or 10; 11 is folded into 01 when latched.
    assign dmode     = (mode_q == 2'b01) | ((mode_q == 2'b10) & ~pass_q);
    assign verify_rd = (mode_q == 2'b10) & pass_q;

    assign ready     = (state_q == StIdle);
    assign done      = (state_q == StDone);
    // Issue waits for the port to be free; the pulse lasts one cycle because ISSUE always
    // advances to ACCEPT on the same condition.
    assign dvalid    = (state_q == StIssue) & dready;
    assign daddr     = {DEV_W'(32'(idx_q) % SLAVE_COUNT),
                        base_q + SLAVE_MEM_ADDR_WIDTH'(idx_q)};
    assign dwdata    = wbuf_q[idx_q];
    assign rb_data   = (32'(rb_idx) < NUM_TXN) ? cbuf_q[rb_idx] : '0;
    assign err_count = err_q;
    assign timeout   = tmo_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        mode_d  = mode_q;
        base_d  = base_q;
        wait_d  = wait_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        cap_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = (mode == 2'b11) ? 2'b01 : mode;
                    base_d  = base_off;
                    idx_d   = '0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wait_d = '0;
                if (dready) state_d = StAccept;
            end
            StAccept: begin
                if (!dready) begin
                    wait_d  = '0;
                    state_d = StComplete;
                end else if (wait_q == WaitMax) begin
                    tmo_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StComplete: begin
                if (dready) begin
                    if (!dmode) begin
                        cap_we = 1'b1;
                        if (verify_rd && (drdata != wbuf_q[idx_q]) && (err_q != 8'hFF)) begin
                            err_d = err_q + 8'd1;
                        end
                    end
                    state_d = StNext;
                end else if (wait_q == WaitMax) begin
                    tmo_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StNext: begin
                if (32'(idx_q) < NUM_TXN - 1) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StIssue;
                end else if ((mode_q == 2'b10) && !pass_q) begin
                    pass_d  = 1'b1;
                    idx_d   = '0;
                    state_d = StIssue;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pass_q  <= 1'b0;
            mode_q  <= 2'b00;
            base_q  <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Pattern and capture buffers deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ld_en && (state_q == StIdle) && (32'(ld_idx) < NUM_TXN)) begin
            wbuf_q[ld_idx] <= ld_data;
        end
        if (cap_we) begin
            cbuf_q[idx_q] <= drdata;
        end
    end

endmodule

// File: doc/seq_traffic_master.md
SEQ_TRAFFIC_MASTER -- requirements
Module: seq_traffic_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning system bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning bus data width.
REQ-003 SHALL have parameter SLAVE_MEM_ADDR_WIDTH, default 12, meaning slave-local address bits; DEV_W = ADDR_WIDTH-SLAVE_MEM_ADDR_WIDTH.
REQ-004 SHALL have parameter SLAVE_COUNT, default 3, meaning number of targeted slaves (1..2^DEV_W).
REQ-005 SHALL have parameter NUM_TXN, default 8, meaning transactions per pass (1..16); IW = clog2(NUM_TXN), minimum 1.
REQ-006 SHALL have parameter TIMEOUT, default 255, meaning maximum wait cycles per transaction phase.
REQ-007 SHALL have ports, in order: clk in 1 clock; rstn in 1 reset, synchronous, active-low.
REQ-008 SHALL have ports start in 1 (sequence request) and mode in 2 (00 read, 01 write, 10 write-then-verify, 11 reserved and treated as 01).
REQ-009 SHALL have ports base_off in SLAVE_MEM_ADDR_WIDTH (first slave-local offset), ready out 1 (idle), done out 1 (one-cycle end pulse).
REQ-010 SHALL have ports ld_en in 1, ld_idx in IW, ld_data in DATA_WIDTH, meaning write-pattern buffer load.
REQ-011 SHALL have ports rb_idx in IW and rb_data out DATA_WIDTH, meaning combinational read-back of the capture buffer.
REQ-012 SHALL have ports err_count out 8 (saturating mismatch count) and timeout out 1 (sticky abort flag).
REQ-013 SHALL have master_port device-side ports: daddr out ADDR_WIDTH, dwdata out DATA_WIDTH, drdata in DATA_WIDTH, dvalid out 1, dready in 1, dmode out 1 (1 write).

Function
REQ-014 SHALL hold wbuf[NUM_TXN] (write pattern) and cbuf[NUM_TXN] (captured read data) as register arrays.
REQ-015 SHALL write ld_data to wbuf[ld_idx] on ld_en only while ready=1; ld_en while busy is ignored.
REQ-016 SHALL address transaction i as daddr = {i mod SLAVE_COUNT on DEV_W bits, (base_off+i) mod 2^SLAVE_MEM_ADDR_WIDTH}.
REQ-017 SHALL drive dwdata = wbuf[i] during writes; dwdata is don't-care during reads.
REQ-018 SHALL implement states IDLE, ISSUE, ACCEPT, COMPLETE, NEXT, DONE.
REQ-019 IDLE: ready=1; on start, SHALL latch mode and base_off, set i=0, pass=0, clear err_count and timeout, and go to ISSUE.
REQ-020 ISSUE: SHALL wait for dready=1, then assert dvalid for exactly one cycle with stable daddr/dmode, and go to ACCEPT.
REQ-021 ACCEPT: SHALL wait for dready=0 (port busy), then go to COMPLETE.
REQ-022 COMPLETE: on dready=1, for reads SHALL capture drdata into cbuf[i] the same cycle, then go to NEXT.
REQ-023 In verify pass 1 (reads), a captured value differing from wbuf[i] SHALL increment err_count, saturating at 255.
REQ-024 NEXT: if i<NUM_TXN-1, SHALL increment i and go to ISSUE; else for mode 10 with pass=0, SHALL set pass=1, i=0 and go to ISSUE; else go to DONE.
REQ-025 dmode SHALL be 1 in mode 01, 0 in mode 00, and in mode 10 SHALL be 1 in pass 0 and 0 in pass 1.
REQ-026 DONE: SHALL assert done for one cycle, then go to IDLE.
REQ-027 A wait counter SHALL clear on entry to ACCEPT and to COMPLETE; if it reaches TIMEOUT, SHALL set timeout=1, drop dvalid and go to DONE.
REQ-028 start while not IDLE SHALL be ignored.
REQ-029 dvalid SHALL never be asserted outside ISSUE.

Reset
REQ-030 With rstn=0 at a clock edge, SHALL return state to IDLE and clear i, pass, dvalid, dmode, done, timeout and err_count, including mid-transaction.
REQ-031 wbuf and cbuf contents SHALL be unaffected by reset.

Verification
REQ-032 Mode 01, base_off=0x010, wbuf=i+0xA0 -> daddrs 0x0010, 0x1011, 0x2012, 0x0013...; eight one-cycle dvalid pulses with dmode=1; done once.
REQ-033 Mode 10 against an ideal slave model -> 16 transactions; err_count=0; cbuf equals wbuf via rb_idx.
REQ-034 Mode 10 with the slave corrupting index 3 -> err_count=1, all other cbuf entries correct.
REQ-035 dready held at 1 after dvalid (never drops) -> timeout=1 after TIMEOUT cycles, done pulses, ready returns.
REQ-036 rstn=0 asserted in COMPLETE -> next cycle ready=1, dvalid=0, err_count=0, and wbuf is preserved.
REQ-037 start pulsed while busy, and ld_en pulsed while busy -> no restart and wbuf unchanged.
